// File: rtl/alu_pkg.sv
// Shared ALU select encodings and the buffered result-word layout.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_CMP = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

    // Flag bit positions within out_flags = {zero, carry, gt, eq, lt}
    localparam int FLAG_LT    = 0;
    localparam int FLAG_EQ    = 1;
    localparam int FLAG_GT    = 2;
    localparam int FLAG_CARRY = 3;
    localparam int FLAG_ZERO  = 4;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] result;
        logic       zero;
        logic       carry;
        logic       gt;
        logic       eq;
        logic       lt;
    } res_word_t;

    localparam int RES_W = $bits(res_word_t);

endpackage

// File: rtl/sync_fifo.sv
// Generic register-based FIFO with wrap-bit pointers and occupancy output.
// Latency: one cycle from push edge to pop_vld; head data comes straight from storage.
// Backpressure: push_rdy = !full from registered state only; clr flushes and drops a same-cycle push.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat,
    output logic [AW:0]      level
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign level    = wr_ptr - rd_ptr;
    assign push_rdy = (level != FULL_LVL);
    assign pop_vld  = (wr_ptr != rd_ptr);
    assign push_en  = push_vld && push_rdy;
    assign pop_en   = pop_vld && pop_rdy;

    // Storage is never reset, so the head is masked whenever the FIFO is empty.
    assign pop_dat = pop_vld ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (push_en && !clr) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/alu_result_fifo.sv
// Captures ALU results, selects the op-relevant field, flags zero, buffers for a slow consumer.
// Latency: one cycle from accepted push to out_valid when empty; no input-to-output comb path.
// Backpressure: in_ready = !full (registered state); a pop while full does not free a slot that cycle.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               sel,
    input  logic [3:0]               sum,
    input  logic                     carry,
    input  logic                     a_gt_b,
    input  logic                     a_eq_b,
    input  logic                     a_st_b,
    input  logic [3:0]               ab,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_op,
    output logic [3:0]               out_result,
    output logic [4:0]               out_flags,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         result_cnt,
    output logic [CNT_W-1:0]         carry_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    res_word_t in_word;
    res_word_t out_word;
    logic      push;

    always_comb begin
        in_word        = '0;
        in_word.op     = sel;
        in_word.gt     = a_gt_b;
        in_word.eq     = a_eq_b;
        in_word.lt     = a_st_b;
        case (sel)
            ALU_ADD, ALU_SUB: begin
                in_word.result = sum;
                in_word.carry  = carry;
            end
            ALU_CMP: in_word.result = {1'b0, a_gt_b, a_eq_b, a_st_b};
            default: in_word.result = ab;
        endcase
        in_word.zero = (in_word.result == 4'd0);
    end

    assign push = in_valid && in_ready;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RES_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat (in_word),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (out_word),
        .level    (level)
    );

    assign out_op     = out_word.op;
    assign out_result = out_word.result;
    assign out_flags  = {out_word.zero, out_word.carry, out_word.gt, out_word.eq, out_word.lt};

    // Statistics saturate rather than wrap; in_word.carry is already masked to add/sub.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_cnt <= '0;
            carry_cnt  <= '0;
        end else if (clr) begin
            result_cnt <= '0;
            carry_cnt  <= '0;
        end else if (push) begin
            if (result_cnt != CNT_MAX) begin
                result_cnt <= result_cnt + CNT_ONE;
            end
            if (in_word.carry && (carry_cnt != CNT_MAX)) begin
                carry_cnt <= carry_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: directed pushes queue hand-computed words,
// a negedge monitor pops and compares every word the DUT hands over.
module tb_alu_result_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] sel;
    logic [3:0] sum;
    logic       carry;
    logic       a_gt_b;
    logic       a_eq_b;
    logic       a_st_b;
    logic [3:0] ab;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_op;
    logic [3:0] out_result;
    logic [4:0] out_flags;
    logic [2:0] level;
    logic [7:0] result_cnt;
    logic [7:0] carry_cnt;

    logic [10:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_push = 0;
    logic        last_acc;

    alu_result_fifo #(.DEPTH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel        (sel),
        .sum        (sum),
        .carry      (carry),
        .a_gt_b     (a_gt_b),
        .a_eq_b     (a_eq_b),
        .a_st_b     (a_st_b),
        .ab         (ab),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_result (out_result),
        .out_flags  (out_flags),
        .level      (level),
        .result_cnt (result_cnt),
        .carry_cnt  (carry_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: every handshake on the output side must match the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_out: got 0x%0h, expected no output at %0t",
                         {out_op, out_result, out_flags}, $time);
            end else begin
                check("out_word", int'({out_op, out_result, out_flags}), int'(exp_q.pop_front()));
            end
        end
    end

    // One cycle of stimulus; exp_w = {op, result, zero, carry, gt, eq, lt} if accepted.
    task automatic step(input logic v, input logic [1:0] s, input logic [3:0] sm,
                        input logic c, input logic g, input logic e, input logic l,
                        input logic [3:0] abv, input logic [10:0] exp_w);
        in_valid = v;
        sel      = s;
        sum      = sm;
        carry    = c;
        a_gt_b   = g;
        a_eq_b   = e;
        a_st_b   = l;
        ab       = abv;
        @(negedge clk);
        last_acc = v && in_ready && !clr;
        if (last_acc) begin
            exp_q.push_back(exp_w);
            n_push++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 11'h0);
    endtask

    task automatic add_plain(input logic [3:0] v);
        step(1'b1, 2'b00, v, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0,
             {2'b00, v, (v == 4'h0), 4'b0000});
    endtask

    task automatic drain();
        int k = 0;
        out_ready = 1'b1;
        while ((out_valid || exp_q.size() != 0) && k < 30) begin
            idle();
            k++;
        end
        check("drain_out_valid", int'(out_valid), 0);
        check("drain_queue_left", exp_q.size(), 0);
        check("drain_level", int'(level), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; sel = 2'b00; sum = 4'h0; carry = 1'b0;
        a_gt_b = 1'b0; a_eq_b = 1'b0; a_st_b = 1'b0; ab = 4'h0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_level", int'(level), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_result_cnt", int'(result_cnt), 0);
        check("rst_carry_cnt", int'(carry_cnt), 0);
        check("rst_out_fields", int'({out_op, out_result, out_flags}), 0);

        // 5+9 add: visible the cycle after the push edge
        step(1'b1, 2'b00, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, {2'b00, 4'b1110, 5'b00000});
        check("add_out_valid", int'(out_valid), 1);
        check("add_out_result", int'(out_result), 'b1110);
        check("add_out_flags", int'(out_flags), 0);
        check("add_result_cnt", int'(result_cnt), 1);
        check("add_carry_cnt", int'(carry_cnt), 0);

        out_ready = 1'b1;
        // 11+5: sum 0000 carry 1, comparator gt
        step(1'b1, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, {2'b00, 4'b0000, 5'b11100});
        check("add_carry_cnt_1", int'(carry_cnt), 1);
        // compare gt: sum/carry inputs must be ignored
        step(1'b1, 2'b10, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, {2'b10, 4'b0100, 5'b00100});
        step(1'b1, 2'b01, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, {2'b01, 4'b0011, 5'b01001});
        step(1'b1, 2'b11, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1010, {2'b11, 4'b1010, 5'b00010});
        step(1'b1, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, {2'b11, 4'b0000, 5'b10010});
        drain();
        check("mix_result_cnt", int'(result_cnt), 6);
        check("mix_carry_cnt", int'(carry_cnt), 2);

        // Fill to full with consumer stalled
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) add_plain(4'(i));
        check("full_in_ready", int'(in_ready), 0);
        check("full_level", int'(level), 4);
        add_plain(4'd5);
        check("full_refused", int'(last_acc), 0);
        check("full_level_hold", int'(level), 4);
        out_ready = 1'b1;
        add_plain(4'd6);
        check("full_pop_no_push", int'(last_acc), 0);
        check("full_pop_level", int'(level), 3);
        drain();

        // Streaming at level 2
        out_ready = 1'b0;
        add_plain(4'd7);
        add_plain(4'd8);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            add_plain(4'((i % 15) + 1));
            check("stream_level", int'(level), 2);
        end
        drain();
        check("stream_result_cnt", int'(result_cnt), n_push);

        // clr with level 3 during a push
        out_ready = 1'b0;
        add_plain(4'd9);
        add_plain(4'd10);
        add_plain(4'd11);
        check("pre_clr_level", int'(level), 3);
        clr = 1'b1;
        add_plain(4'd12);
        clr = 1'b0;
        exp_q.delete();
        n_push = 0;
        check("clr_level", int'(level), 0);
        check("clr_out_valid", int'(out_valid), 0);
        check("clr_result_cnt", int'(result_cnt), 0);
        check("clr_carry_cnt", int'(carry_cnt), 0);
        out_ready = 1'b1;
        repeat (4) idle();
        check("clr_stays_empty", int'(out_valid), 0);

        // Saturation: 260 pushes with carry on add
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 2'b00, 4'(i), 1'b1, 1'b0, 1'b0, 1'b0, 4'h0,
                 {2'b00, 4'(i), (4'(i) == 4'h0), 1'b1, 3'b000});
        end
        drain();
        check("sat_push_count", n_push, 260);
        check("sat_result_cnt", int'(result_cnt), 255);
        check("sat_carry_cnt", int'(carry_cnt), 255);

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        add_plain(4'd3);
        add_plain(4'd4);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        n_push = 0;
        check("arst_level", int'(level), 0);
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_result_cnt", int'(result_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) idle();
        check("arst_no_emit", int'(out_valid), 0);
        check("arst_in_ready", int'(in_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
